corelet_ctrl: RTL and testbench

- Top-level sequencer for one corelet (L0 FIFO, MAC array, OFIFO, SFP) plus its activation/weight SRAM (xmem) and psum SRAM (pmem).
- On `start`, runs one full convolution tile:
  - for each kernel index kij: load weights, stream activations, drain psums to pmem;
  - then an accumulation pass that sums kij partials per output pixel through the SFP and writes final outputs.
- Drives the corelet's 9-bit `inst` word and both SRAM ports; replaces the testbench-driven instruction sequence.

---
 rtl/corelet_ctrl_pkg.sv | 55 +++++
 rtl/corelet_ctrl_if.sv | 31 +++
 rtl/corelet_ctrl_conv_addr_gen.sv | 58 +++++
 rtl/corelet_ctrl.sv | 155 +++++++++++++++
 tb/tb_corelet_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/corelet_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | corelet_ctrl_pkg - shared geometry, inst bit map, FSM states  r1.0 |
// +------------------------------------------------------------------+
package corelet_ctrl_pkg;

   localparam int ROW      = 8;
   localparam int COL      = 8;
   localparam int KSIZE    = 3;
   localparam int IN_W     = 6;
   localparam int OUT_W    = IN_W - KSIZE + 1;
   localparam int ADDR_BW  = 11;
   localparam int W_BASE   = 0;
   localparam int X_BASE   = 1024;
   localparam int OUT_BASE = 1536;

   localparam int LEN_KIJ  = KSIZE * KSIZE;
   localparam int LEN_NIJ  = IN_W * IN_W;
   localparam int LEN_ONIJ = OUT_W * OUT_W;

   localparam int INST_KLOAD    = 0;
   localparam int INST_EXEC     = 1;
   localparam int INST_L0_WR    = 2;
   localparam int INST_L0_RD    = 3;
   localparam int INST_IFIFO_RD = 4;
   localparam int INST_IFIFO_WR = 5;
   localparam int INST_OFIFO_RD = 6;
   localparam int INST_SFP_SEL  = 7;
   localparam int INST_RELU     = 8;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Largest value any phase counter reaches inside one state
   localparam int CNT_MAX = max2(max2(LEN_NIJ, COL) + 1, max2(2*COL + ROW, LEN_KIJ + 2));
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int KIJ_W   = $clog2(LEN_KIJ + 1);
   localparam int KC_W    = $clog2(KSIZE + 1);
   localparam int OC_W    = $clog2(OUT_W + 1);
   localparam int ONIJ_W  = $clog2(LEN_ONIJ + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_W_L0  = 3'd1,
      S_W_ARR = 3'd2,
      S_X_L0  = 3'd3,
      S_X_EXE = 3'd4,
      S_DRAIN = 3'd5,
      S_ACC   = 3'd6,
      S_DONE  = 3'd7
   } state_t;

endpackage
`default_nettype wire

// File: rtl/corelet_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | corelet_ctrl_if - control/instruction/SRAM bundle of the corelet r1.0 |
// +------------------------------------------------------------------+
interface corelet_ctrl_if;
   import corelet_ctrl_pkg::*;

   logic               start;
   logic               relu_en;
   logic               o_valid;
   logic [8:0]         inst;
   logic               xmem_cen;
   logic [ADDR_BW-1:0] xmem_addr;
   logic               pmem_cen;
   logic               pmem_wen;
   logic [ADDR_BW-1:0] pmem_addr;
   logic               sfp_first;
   logic               busy;
   logic               done;

   modport master (
      input  start, relu_en, o_valid,
      output inst, xmem_cen, xmem_addr, pmem_cen, pmem_wen, pmem_addr, sfp_first, busy, done
   );

   modport slave (
      output start, relu_en, o_valid,
      input  inst, xmem_cen, xmem_addr, pmem_cen, pmem_wen, pmem_addr, sfp_first, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/corelet_ctrl_conv_addr_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | conv_addr_gen - psum read / final write addresses for ACC     r1.0 |
// +------------------------------------------------------------------+
module conv_addr_gen
   import corelet_ctrl_pkg::*;
(
   input  wire logic               clk,
   input  wire logic               reset,
   input  wire logic               i_clr,
   input  wire logic               i_k_step,
   input  wire logic               i_o_step,
   output logic [ADDR_BW-1:0]      o_rd_addr,
   output logic [ADDR_BW-1:0]      o_wr_addr,
   output logic                    o_o_last
);
   logic [KIJ_W-1:0]  r_kk;
   logic [KC_W-1:0]   r_kr, r_kc;
   logic [OC_W-1:0]   r_or, r_oc;
   logic [ONIJ_W-1:0] r_o;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_kk <= '0; r_kr <= '0; r_kc <= '0;
         r_or <= '0; r_oc <= '0; r_o  <= '0;
      end else if (i_clr) begin
         r_kk <= '0; r_kr <= '0; r_kc <= '0;
         r_or <= '0; r_oc <= '0; r_o  <= '0;
      end else begin
         if (i_k_step) begin
            r_kk <= (r_kk == KIJ_W'(LEN_KIJ-1)) ? '0 : r_kk + 1'b1;
            if (r_kc == KC_W'(KSIZE-1)) begin
               r_kc <= '0;
               r_kr <= (r_kr == KC_W'(KSIZE-1)) ? '0 : r_kr + 1'b1;
            end else begin
               r_kc <= r_kc + 1'b1;
            end
         end
         if (i_o_step) begin
            r_o <= r_o + 1'b1;
            if (r_oc == OC_W'(OUT_W-1)) begin
               r_oc <= '0;
               r_or <= r_or + 1'b1;
            end else begin
               r_oc <= r_oc + 1'b1;
            end
         end
      end
   end

   // Row/column counters keep the pixel index multiply-by-constant only
   assign o_rd_addr = ADDR_BW'(int'(r_kk) * LEN_NIJ
                             + (int'(r_or) + int'(r_kr)) * IN_W
                             + int'(r_oc) + int'(r_kc));
   assign o_wr_addr = ADDR_BW'(OUT_BASE + int'(r_o));
   assign o_o_last  = (r_o == ONIJ_W'(LEN_ONIJ-1));
endmodule
`default_nettype wire

// File: rtl/corelet_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | corelet_ctrl - sequences one convolution tile through a corelet r1.0 |
// +------------------------------------------------------------------+
module corelet_ctrl
   import corelet_ctrl_pkg::*;
(
   input  wire logic       clk,
   input  wire logic       reset,
   corelet_ctrl_if.master  bus
);
   localparam logic [CNT_W-1:0] c_COL      = CNT_W'(COL);
   localparam logic [CNT_W-1:0] c_WARR_END = CNT_W'(2*COL + ROW - 1);
   localparam logic [CNT_W-1:0] c_NIJ      = CNT_W'(LEN_NIJ);
   localparam logic [CNT_W-1:0] c_NIJ_END  = CNT_W'(LEN_NIJ - 1);
   localparam logic [CNT_W-1:0] c_KIJ      = CNT_W'(LEN_KIJ);
   localparam logic [CNT_W-1:0] c_ACC_WR   = CNT_W'(LEN_KIJ + 1);

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, r_aux;
   logic [KIJ_W-1:0]   r_kij;
   logic               r_relu, r_l0_wr, r_wr_pend;
   logic               w_xrd, w_ofifo_rd;
   logic [ADDR_BW-1:0] w_acc_rd_addr, w_acc_wr_addr;
   logic               w_o_last, w_acc_rd, w_acc_wr;

   assign w_acc_rd = (r_state == S_ACC) && (r_cnt < c_KIJ);
   assign w_acc_wr = (r_state == S_ACC) && (r_cnt == c_ACC_WR);

   conv_addr_gen u_addr_gen (
      .clk       (clk),
      .reset     (reset),
      .i_clr     (r_state != S_ACC),
      .i_k_step  (w_acc_rd),
      .i_o_step  (w_acc_wr),
      .o_rd_addr (w_acc_rd_addr),
      .o_wr_addr (w_acc_wr_addr),
      .o_o_last  (w_o_last)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.start)              w_state_nxt = S_W_L0;
         S_W_L0:  if (r_cnt == c_COL)         w_state_nxt = S_W_ARR;
         S_W_ARR: if (r_cnt == c_WARR_END)    w_state_nxt = S_X_L0;
         S_X_L0:  if (r_cnt == c_NIJ)         w_state_nxt = S_X_EXE;
         S_X_EXE: if (r_cnt == c_NIJ_END)     w_state_nxt = S_DRAIN;
         S_DRAIN: if (r_wr_pend && r_cnt == c_NIJ_END)
                     w_state_nxt = (r_kij == KIJ_W'(LEN_KIJ-1)) ? S_ACC : S_W_L0;
         S_ACC:   if (w_acc_wr && w_o_last)   w_state_nxt = S_DONE;
         S_DONE:                              w_state_nxt = S_IDLE;
         default:                             w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_xrd          = 1'b0;
      w_ofifo_rd     = 1'b0;
      bus.inst       = '0;
      bus.xmem_addr  = '0;
      bus.pmem_cen   = 1'b1;
      bus.pmem_wen   = 1'b1;
      bus.pmem_addr  = '0;
      bus.sfp_first  = 1'b0;
      bus.busy       = (r_state != S_IDLE) && (r_state != S_DONE);
      bus.done       = (r_state == S_DONE);
      bus.inst[INST_L0_WR]    = r_l0_wr;
      bus.inst[INST_IFIFO_RD] = 1'b0;
      bus.inst[INST_IFIFO_WR] = 1'b0;
      case (r_state)
         S_W_L0: if (r_cnt < c_COL) begin
            w_xrd         = 1'b1;
            bus.xmem_addr = ADDR_BW'(W_BASE + int'(r_kij) * COL + int'(r_cnt));
         end
         S_W_ARR: if (r_cnt < c_COL) begin
            bus.inst[INST_L0_RD] = 1'b1;
            bus.inst[INST_KLOAD] = 1'b1;
         end
         S_X_L0: if (r_cnt < c_NIJ) begin
            w_xrd         = 1'b1;
            bus.xmem_addr = ADDR_BW'(X_BASE + int'(r_cnt));
         end
         S_X_EXE: begin
            bus.inst[INST_L0_RD] = 1'b1;
            bus.inst[INST_EXEC]  = 1'b1;
         end
         S_DRAIN: begin
            // r_aux counts rows popped; never pop beyond one tile's worth
            w_ofifo_rd              = bus.o_valid && (r_aux < c_NIJ);
            bus.inst[INST_OFIFO_RD] = w_ofifo_rd;
            if (r_wr_pend) begin
               bus.pmem_cen  = 1'b0;
               bus.pmem_wen  = 1'b0;
               bus.pmem_addr = ADDR_BW'(int'(r_kij) * LEN_NIJ + int'(r_cnt));
            end
         end
         S_ACC: begin
            bus.inst[INST_SFP_SEL] = 1'b1;
            bus.inst[INST_RELU]    = r_relu;
            bus.sfp_first          = (r_cnt == CNT_W'(1));
            if (w_acc_rd) begin
               bus.pmem_cen  = 1'b0;
               bus.pmem_addr = w_acc_rd_addr;
            end else if (w_acc_wr) begin
               bus.pmem_cen  = 1'b0;
               bus.pmem_wen  = 1'b0;
               bus.pmem_addr = w_acc_wr_addr;
            end
         end
         default: ;
      endcase
      bus.xmem_cen = !w_xrd;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt     <= '0;
         r_aux     <= '0;
         r_kij     <= '0;
         r_relu    <= 1'b0;
         r_l0_wr   <= 1'b0;
         r_wr_pend <= 1'b0;
      end else begin
         r_l0_wr   <= w_xrd;
         r_wr_pend <= w_ofifo_rd;
         if (r_state == S_IDLE && bus.start) begin
            r_relu <= bus.relu_en;
            r_kij  <= '0;
         end
         if (r_state == S_DRAIN && w_state_nxt == S_W_L0)
            r_kij <= r_kij + 1'b1;
         if (w_state_nxt != r_state) begin
            r_cnt <= '0;
            r_aux <= '0;
         end else begin
            case (r_state)
               S_IDLE, S_DONE: r_cnt <= '0;
               S_DRAIN: begin
                  r_cnt <= r_cnt + CNT_W'(r_wr_pend);
                  r_aux <= r_aux + CNT_W'(w_ofifo_rd);
               end
               S_ACC:   r_cnt <= (r_cnt == c_ACC_WR) ? '0 : r_cnt + 1'b1;
               default: r_cnt <= r_cnt + 1'b1;
            endcase
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_corelet_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_corelet_ctrl - randomized tile runs against a loop-level model r1.0 |
// +------------------------------------------------------------------+
module tb_corelet_ctrl;
   import corelet_ctrl_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b0;

   corelet_ctrl_if ifc ();

   corelet_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.master)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;
   int cyc_no = 0, done_cyc = 0;
   int n_drainw = 0, n_outw = 0, n_done = 0;

   bit         exp_on = 1'b0;
   logic [8:0] exp_inst;
   bit         exp_xcen, exp_pcen, exp_pwen, exp_first, exp_busy, exp_done;
   int         exp_xaddr, exp_paddr;

   task automatic check(input string nm, input int act, input int req);
      n_chk++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, req);
   endtask

   task automatic exp_idle();
      exp_inst = '0; exp_xcen = 1'b1; exp_xaddr = 0;
      exp_pcen = 1'b1; exp_pwen = 1'b1; exp_paddr = 0;
      exp_first = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
   endtask

   task automatic exp_run();
      exp_idle();
      exp_busy = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rnd_inputs(input bit pokes);
      ifc.o_valid = 1'($urandom_range(1, 0));
      ifc.relu_en = 1'($urandom_range(1, 0));
      ifc.start   = pokes ? ($urandom_range(3, 0) == 0) : 1'b0;
   endtask

   always @(negedge clk) begin
      bit ok;
      cyc_no++;
      if (reset && !ifc.pmem_cen && !ifc.pmem_wen) begin
         if (int'(ifc.pmem_addr) >= OUT_BASE) n_outw++;
         else                                 n_drainw++;
      end
      if (reset && ifc.done) begin
         n_done++;
         done_cyc = cyc_no;
      end
      if (exp_on) begin
         ok = (ifc.inst == exp_inst) && (ifc.xmem_cen == exp_xcen)
           && (exp_xcen || ifc.xmem_addr == ADDR_BW'(exp_xaddr))
           && (ifc.pmem_cen == exp_pcen) && (ifc.pmem_wen == exp_pwen)
           && (exp_pcen || ifc.pmem_addr == ADDR_BW'(exp_paddr))
           && (ifc.sfp_first == exp_first) && (ifc.busy == exp_busy)
           && (ifc.done == exp_done);
         n_chk++;
         if (ok) n_pass++;
         else $display("FAIL outputs cyc %0d (got/exp): inst %h/%h xcen %0d/%0d xaddr %0d/%0d pcen %0d/%0d pwen %0d/%0d paddr %0d/%0d first %0d/%0d busy %0d/%0d done %0d/%0d",
                       cyc_no, ifc.inst, exp_inst, ifc.xmem_cen, exp_xcen, ifc.xmem_addr, exp_xaddr,
                       ifc.pmem_cen, exp_pcen, ifc.pmem_wen, exp_pwen, ifc.pmem_addr, exp_paddr,
                       ifc.sfp_first, exp_first, ifc.busy, exp_busy, ifc.done, exp_done);
      end
   end

   // vmode: 0 = o_valid tied high in DRAIN, 1 = toggling 1-0-1, 2 = random
   task automatic run_tile(input bit relu, input int vmode, input bit pokes, input bit abort);
      int  start_cyc, wr, rd, guard, orow, ocol;
      bit  pend, tog, ov, rdn;
      n_drainw = 0; n_outw = 0; n_done = 0;

      exp_idle();
      ifc.start = 1'b1; ifc.relu_en = relu; ifc.o_valid = 1'($urandom_range(1, 0));
      start_cyc = cyc_no + 1;
      step();

      for (int kij = 0; kij < LEN_KIJ; kij++) begin
         for (int i = 0; i <= COL; i++) begin
            rnd_inputs(pokes); exp_run();
            if (i < COL) begin exp_xcen = 1'b0; exp_xaddr = W_BASE + kij*COL + i; end
            exp_inst[INST_L0_WR] = (i > 0);
            step();
         end
         for (int i = 0; i < 2*COL + ROW; i++) begin
            rnd_inputs(pokes); exp_run();
            if (i < COL) begin exp_inst[INST_L0_RD] = 1'b1; exp_inst[INST_KLOAD] = 1'b1; end
            step();
         end
         for (int j = 0; j <= LEN_NIJ; j++) begin
            rnd_inputs(pokes); exp_run();
            if (j < LEN_NIJ) begin exp_xcen = 1'b0; exp_xaddr = X_BASE + j; end
            exp_inst[INST_L0_WR] = (j > 0);
            step();
         end
         for (int j = 0; j < LEN_NIJ; j++) begin
            rnd_inputs(pokes); exp_run();
            exp_inst[INST_L0_RD] = 1'b1; exp_inst[INST_EXEC] = 1'b1;
            if (abort && j == 5) begin
               reset = 1'b0; ifc.start = 1'b0;
               exp_idle();
               #2;
               check("abort_inst", int'(ifc.inst), 0);
               check("abort_xcen", int'(ifc.xmem_cen), 1);
               check("abort_pwen", int'(ifc.pmem_wen), 1);
               check("abort_busy", int'(ifc.busy), 0);
               step(); step();
               reset = 1'b1;
               step();
               return;
            end
            step();
         end
         wr = 0; rd = 0; guard = 0; pend = 1'b0; tog = 1'b1;
         while (wr < LEN_NIJ) begin
            rnd_inputs(pokes);
            case (vmode)
               0:       ov = 1'b1;
               1:       begin ov = tog; tog = !tog; end
               default: ov = 1'($urandom_range(1, 0));
            endcase
            ifc.o_valid = ov;
            rdn = ov && (rd < LEN_NIJ);
            exp_run();
            exp_inst[INST_OFIFO_RD] = rdn;
            if (pend) begin
               exp_pcen = 1'b0; exp_pwen = 1'b0; exp_paddr = kij*LEN_NIJ + wr;
               wr++;
            end
            rd += int'(rdn);
            pend = rdn;
            step();
            guard++;
            if (guard > 1000) begin check("drain_bound", guard, 0); break; end
         end
      end

      for (int o = 0; o < LEN_ONIJ; o++) begin
         orow = o / OUT_W; ocol = o % OUT_W;
         for (int t = 0; t < LEN_KIJ + 2; t++) begin
            rnd_inputs(pokes); exp_run();
            exp_inst[INST_SFP_SEL] = 1'b1; exp_inst[INST_RELU] = relu;
            exp_first = (t == 1);
            if (t < LEN_KIJ) begin
               exp_pcen = 1'b0;
               exp_paddr = t*LEN_NIJ + (orow + t/KSIZE)*IN_W + ocol + t%KSIZE;
            end else if (t == LEN_KIJ + 1) begin
               exp_pcen = 1'b0; exp_pwen = 1'b0; exp_paddr = OUT_BASE + o;
            end
            if (o == 5 && t == 4) begin
               @(negedge clk);
               check("acc_addr_o5_k4", int'(ifc.pmem_addr), 158);
            end
            step();
         end
      end

      ifc.start = 1'b0;
      exp_idle(); exp_done = 1'b1;
      step();
      exp_idle();
      step();

      check("drain_writes", n_drainw, LEN_KIJ*36);
      check("out_writes", n_outw, 16);
      check("done_pulses", n_done, 1);
      if (vmode == 0) check("start_to_done", done_cyc - start_cyc, 1464);
   endtask

   initial begin
      ifc.start = 1'b0; ifc.relu_en = 1'b0; ifc.o_valid = 1'b0;
      repeat (2) step();
      exp_idle(); exp_on = 1'b1;
      #2;
      check("rst_inst", int'(ifc.inst), 0);
      check("rst_xcen", int'(ifc.xmem_cen), 1);
      check("rst_pcen", int'(ifc.pmem_cen), 1);
      check("rst_pwen", int'(ifc.pmem_wen), 1);
      check("rst_busy", int'(ifc.busy), 0);
      step();
      reset = 1'b1;
      step();
      step();

      run_tile(1'b0, 0, 1'b0, 1'b1);
      run_tile(1'b1, 0, 1'b1, 1'b0);
      run_tile(1'b0, 1, 1'b0, 1'b0);
      run_tile(1'b1, 2, 1'b1, 1'b0);

      exp_on = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
`default_nettype wire
